// File: rtl/firc_out_fifo.sv
// firc_out_fifo: first-word-fall-through output buffer behind the complex FIR.
// The filter cannot stall, so this block never back-pressures it. A result
// that arrives while the FIFO is full is dropped, counted and flagged.
// Only the head entry is visible to the sink, over a valid/ready handshake.

// One storage slot holding a {I,Q} pair. The slot is written only when its
// write enable is set. It has no reset: after a reset the slot contents are
// stale, but they are never presented as valid data.
module firc_out_fifo_entry #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           we,
    input  logic [2*W-1:0] d,
    output logic [2*W-1:0] q
);

    // Capture the pushed pair when this slot is the write target.
    always_ff @(posedge clk) begin
        if (we) q <= d;
    end

endmodule

module firc_out_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                       clk,
    input  logic                       Reset_n,
    input  logic                       PushIn,
    input  logic [W-1:0]               FI,
    input  logic [W-1:0]               FQ,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [W-1:0]               OutI,
    output logic [W-1:0]               OutQ,
    output logic [$clog2(DEPTH):0]     Level,
    output logic                       AlmostFull,
    output logic                       Overflow,
    output logic [7:0]                 DropCount,
    input  logic                       ClearErr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [PW-1:0]                 wp;
    logic [PW-1:0]                 rp;
    logic [LW-1:0]                 level;
    logic [LW-1:0]                 level_nxt;
    logic                          af;
    logic                          ovf;
    logic [7:0]                    drop_cnt;

    logic                          full;
    logic                          valid;
    logic                          pop;
    logic                          push;
    logic                          drop;

    logic [DEPTH-1:0]              we;
    logic [DEPTH-1:0][2*W-1:0]     rd_data;
    logic [2*W-1:0]                head;

    // Handshake decode. A push into a full FIFO is still accepted when the
    // head is popped on the same edge, because that pop frees the slot.
    assign full  = (level == LW'(DEPTH));
    assign valid = (level != '0);
    assign pop   = valid && OutReady;
    assign push  = PushIn && (!full || pop);
    assign drop  = PushIn && !push;

    // Storage array: one slot per entry, selected by the write pointer.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        assign we[g] = push && (wp == PW'(g));

        firc_out_fifo_entry #(
            .W (W)
        ) u_entry (
            .clk (clk),
            .we  (we[g]),
            .d   ({FI, FQ}),
            .q   (rd_data[g])
        );
    end

    // Head of queue is read straight out of the registers (fall-through).
    assign head = rd_data[rp];

    // Occupancy after this edge: +1 push only, -1 pop only, else unchanged.
    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + LW'(1);
        else if (pop && !push) level_nxt = level - LW'(1);
    end

    // Pointers, occupancy and the almost-full flag, all updated on the edge
    // that moves data. Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            af    <= 1'b0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            level <= level_nxt;
            af    <= (level_nxt >= LW'(DEPTH - 2));
        end
    end

    // Sticky drop flag and saturating drop counter; a clear beats a drop
    // arriving on the same edge.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (ClearErr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign OutValid   = valid;
    assign OutI       = head[2*W-1:W];
    assign OutQ       = head[W-1:0];
    assign Level      = level;
    assign AlmostFull = af;
    assign Overflow   = ovf;
    assign DropCount  = drop_cnt;

endmodule

// File: tb/tb_firc_out_fifo.sv
// Testbench for firc_out_fifo: directed vector table, hand-written corner
// sequences (drop saturation, async reset) and a randomized stream checked
// against a queue-based reference model.
module tb_firc_out_fifo;

    localparam int DEPTH = 8;
    localparam int W     = 32;

    logic          clk = 1'b0;
    logic          Reset_n;
    logic          PushIn;
    logic [W-1:0]  FI;
    logic [W-1:0]  FQ;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  OutI;
    logic [W-1:0]  OutQ;
    logic [3:0]    Level;
    logic          AlmostFull;
    logic          Overflow;
    logic [7:0]    DropCount;
    logic          ClearErr;

    int total = 0;
    int bad   = 0;

    firc_out_fifo #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .PushIn     (PushIn),
        .FI         (FI),
        .FQ         (FQ),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutI       (OutI),
        .OutQ       (OutQ),
        .Level      (Level),
        .AlmostFull (AlmostFull),
        .Overflow   (Overflow),
        .DropCount  (DropCount),
        .ClearErr   (ClearErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] fi;
        logic [31:0] fq;
        logic        rdy;
        logic        clr;
        logic        v;
        int          lvl;
        logic        af;
        logic        ovf;
        int          drop;
        logic [31:0] ei;
        logic [31:0] eq;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic push, input logic [31:0] fi, input logic [31:0] fq,
                       input logic rdy, input logic clr, input logic v, input int lvl,
                       input logic af, input logic ovf, input int drop,
                       input logic [31:0] ei, input logic [31:0] eq);
        vec_t r;
        r.push = push; r.fi = fi; r.fq = fq; r.rdy = rdy; r.clr = clr;
        r.v = v; r.lvl = lvl; r.af = af; r.ovf = ovf; r.drop = drop;
        r.ei = ei; r.eq = eq;
        tbl.push_back(r);
    endtask

    function automatic logic [31:0] neg(input int k);
        logic [31:0] r;
        r = 32'(-k);
        return r;
    endfunction

    task automatic drive(input logic push, input logic [31:0] fi, input logic [31:0] fq,
                         input logic rdy, input logic clr);
        PushIn = push; FI = fi; FQ = fq; OutReady = rdy; ClearErr = clr;
    endtask

    // One full cycle: inputs were driven at a negedge, step to the next one.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic v, input int lvl, input logic af,
                               input logic ovf, input int drop,
                               input logic [31:0] ei, input logic [31:0] eq);
        chk({tag, ".valid"}, 64'(OutValid), 64'(v));
        chk({tag, ".level"}, 64'(Level), 64'(lvl));
        chk({tag, ".afull"}, 64'(AlmostFull), 64'(af));
        chk({tag, ".ovf"},   64'(Overflow), 64'(ovf));
        chk({tag, ".drops"}, 64'(DropCount), 64'(drop));
        if (v) begin
            chk({tag, ".outi"}, 64'(OutI), 64'(ei));
            chk({tag, ".outq"}, 64'(OutQ), 64'(eq));
        end
    endtask

    initial begin
        logic [63:0] mq[$];
        int          mdrop;
        logic        movf;
        int          sz0;
        logic        mpop;
        logic        r_rdy;
        logic [31:0] r_i;
        logic [31:0] r_q;

        Reset_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_state("reset", 1'b0, 0, 1'b0, 1'b0, 0, '0, '0);
        Reset_n = 1'b1;
        @(negedge clk);

        // ---------------- directed vector table ----------------
        add(1, 32'h0000_1234, 32'hFFFF_EDCC, 0, 0, 1, 1, 0, 0, 0, 32'h0000_1234, 32'hFFFF_EDCC);
        add(0, '0, '0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
        for (int k = 1; k <= 8; k++)
            add(1, 32'(k), neg(k), 0, 0, 1, k, (k >= 6), 0, 0, 32'd1, neg(1));
        for (int j = 1; j <= 3; j++)
            add(1, 32'(100 + j), 32'(200 + j), 0, 0, 1, 8, 1, 1, j, 32'd1, neg(1));
        for (int k = 1; k <= 8; k++)
            add(0, '0, '0, 1, 0, (k < 8), 8 - k, (8 - k >= 6), 1, 3, 32'(k + 1), neg(k + 1));
        add(0, '0, '0, 0, 1, 0, 0, 0, 0, 0, '0, '0);
        for (int k = 11; k <= 18; k++)
            add(1, 32'(k), neg(k), 0, 0, 1, k - 10, (k - 10 >= 6), 0, 0, 32'd11, neg(11));
        // drop and clear on the same edge: the clear wins
        add(1, 32'd77, 32'd77, 0, 1, 1, 8, 1, 0, 0, 32'd11, neg(11));
        // full, push with pop: accepted
        add(1, 32'd99, neg(99), 1, 0, 1, 8, 1, 0, 0, 32'd12, neg(12));
        for (int i = 1; i <= 8; i++)
            add(0, '0, '0, 1, 0, (i < 8), 8 - i, (8 - i >= 6), 0, 0,
                (i < 7) ? 32'(12 + i) : 32'd99, (i < 7) ? neg(12 + i) : neg(99));

        foreach (tbl[n]) begin
            drive(tbl[n].push, tbl[n].fi, tbl[n].fq, tbl[n].rdy, tbl[n].clr);
            tick();
            check_state($sformatf("vec%0d", n), tbl[n].v, tbl[n].lvl, tbl[n].af,
                        tbl[n].ovf, tbl[n].drop, tbl[n].ei, tbl[n].eq);
        end

        // ---------------- drop counter saturation ----------------
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'(500 + k), 32'(600 + k), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, 32'hDEAD_0000, 32'hBEEF_0000, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check_state("sat", 1'b1, 8, 1'b1, 1'b1, 255, 32'd500, 32'd600);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            tick();
        end
        check_state("satdrain", 1'b0, 0, 1'b0, 1'b0, 0, '0, '0);

        // ---------------- randomized stream vs queue model ----------------
        mdrop = 0;
        movf  = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            r_rdy = ($urandom % 4) != 0;
            r_i   = $urandom;
            r_q   = $urandom;
            drive(1'b1, r_i, r_q, r_rdy, 1'b0);
            sz0 = mq.size();
            chk("rnd.valid", 64'(OutValid), 64'(sz0 != 0));
            chk("rnd.level", 64'(Level), 64'(sz0));
            chk("rnd.afull", 64'(AlmostFull), 64'(sz0 >= DEPTH - 2));
            chk("rnd.drops", 64'(DropCount), 64'(mdrop));
            chk("rnd.ovf",   64'(Overflow), 64'(movf));
            if (sz0 != 0) chk("rnd.data", {OutI, OutQ}, mq[0]);
            mpop = (sz0 != 0) && r_rdy;
            if (mpop) void'(mq.pop_front());
            if (sz0 < DEPTH || mpop) mq.push_back({r_i, r_q});
            else begin
                movf = 1'b1;
                if (mdrop < 255) mdrop++;
            end
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("rnd.final_drops", 64'(DropCount), 64'(mdrop));
        chk("rnd.final_level", 64'(Level), 64'(mq.size()));
        while (mq.size() != 0) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            chk("rnd.tail", {OutI, OutQ}, mq[0]);
            void'(mq.pop_front());
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        chk("rnd.empty", 64'(OutValid), 64'(0));

        // ---------------- async reset with Level=5 ----------------
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 32'(700 + k), 32'(800 + k), 1'b0, 1'b0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check_state("prerst", 1'b1, 5, 1'b0, 1'b1, 1, 32'd703, 32'd803);
        @(posedge clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst.valid", 64'(OutValid), 64'(0));
        chk("arst.level", 64'(Level), 64'(0));
        chk("arst.ovf",   64'(Overflow), 64'(0));
        chk("arst.drops", 64'(DropCount), 64'(0));
        @(negedge clk);
        Reset_n = 1'b1;
        drive(1'b1, 32'h0000_ABCD, 32'hFFFF_5433, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check_state("postrst", 1'b1, 1, 1'b0, 1'b0, 0, 32'h0000_ABCD, 32'hFFFF_5433);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/firc_out_fifo.md
# firc_out_fifo

Output buffer stage directly downstream of the complex FIR filter (`firc`). It captures every filter result presented on `PushOut`/`FI`/`FQ` into a DEPTH-entry first-word-fall-through FIFO and drains it to the sink over a valid/ready handshake. The filter cannot be stalled, so the block never back-pressures it. Results arriving while the FIFO is full are dropped, counted, and flagged with a sticky error.

## Interface
- `DEPTH`, 8: number of entries. Must be a power of two, ≥ 4.
- `W`, 32: width of each of the I and Q words.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `Reset_n`  in  1: reset, asynchronous and active-low. Deassertion is synchronous to `clk`, supplied externally.
- `PushIn`  in  1: filter result valid (the filter's `PushOut`).
- `FI`  in  W: filter in-phase result, two's complement.
- `FQ`  in  W: filter quadrature result, two's complement.
- `OutValid`  out  1: head entry is available.
- `OutReady`  in  1: sink accepts the head entry this cycle.
- `OutI`  out  W: head entry, I word.
- `OutQ`  out  W: head entry, Q word.
- `Level`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `AlmostFull`  out  1: `Level >= DEPTH-2`.
- `Overflow`  out  1: sticky flag, set by any dropped push.
- `DropCount`  out  8: number of dropped pushes, saturates at 255.
- `ClearErr`  in  1: synchronous clear of `Overflow` and `DropCount`.

## Operation
- Storage is a DEPTH×(2W) register array with write pointer `wp`, read pointer `rp`, and count `Level`.
  - Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - Full is `Level==DEPTH`. Empty is `Level==0`.
- Push condition: `PushIn && (!full || pop)`. On push, `{FI,FQ}` is written to `mem[wp]` and `wp` increments.
- Pop condition: `OutValid && OutReady`. On pop, `rp` increments.
- `Level` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Full and push with pop in the same cycle: the push is accepted, not dropped, because the pop frees the slot in the same edge.
- Full and push without pop: data is discarded, and `wp`, `Level` and `mem` are unchanged.
  - `Overflow` is set to 1.
  - `DropCount` increments unless it is already 255.
- Empty and push with `OutReady` high: no pop occurs, because `OutValid` is 0 that cycle. The entry is stored normally.
- `ClearErr` in the same cycle as a drop: the clear wins. `Overflow` becomes 0 and `DropCount` becomes 0.
- `OutReady` while `OutValid` is 0 has no effect.
- `OutI`/`OutQ` are undefined-but-stable (the `mem[rp]` contents) while `OutValid` is 0. The sink must ignore them.
- No arithmetic is applied to the data. Words pass bit-exact.
- Reset asserted mid-operation: all entries are discarded immediately and asynchronously. Contents of `mem` are not cleared.

## Timing
- Reset values: `OutValid`=0, `Level`=0, `AlmostFull`=0, `Overflow`=0, `DropCount`=0, `wp`=`rp`=0. `OutI`/`OutQ` are don't-care.
- Latency: a push at edge N gives `OutValid`=1 and the head data on `OutI`/`OutQ` after edge N. This is a one-cycle fall-through.
- `OutValid` is `Level!=0`, and is registered through `Level`.
- `OutI`/`OutQ` are `mem[rp]`, read combinationally from registers. They change only after a pop or after the first push into an empty FIFO.
- `OutValid` and `OutI`/`OutQ` hold stable while `OutReady` is low.
- Throughput: one push and one pop per cycle, sustained indefinitely at any occupancy.
- `Level`, `AlmostFull`, `Overflow` and `DropCount` are all registered and update on the same edge as the event that causes them.

## Test plan
- Reset, then a single push of FI=32'h0000_1234, FQ=32'hFFFF_EDCC with `OutReady`=0.
  - Next cycle: `OutValid`=1, `OutI`=32'h0000_1234, `OutQ`=32'hFFFF_EDCC, `Level`=1.
  - Raise `OutReady` for one cycle: `OutValid`=0 and `Level`=0 after that edge.
- Fill: 8 consecutive pushes of I=k, Q=−k (k=1..8) with `OutReady`=0.
  - Expect `Level`=8 and `AlmostFull`=1 from `Level`=6.
  - Then drain with `OutReady`=1. Expect outputs in order 1..8, Q=−1..−8, with no bubbles.
- Overflow: with the FIFO full, push 3 more values and no pop.
  - Expect `Overflow`=1, `DropCount`=3, `Level`=8.
  - Drain: only the original 8 values appear.
  - Pulse `ClearErr`: `Overflow`=0, `DropCount`=0.
- Full with simultaneous push and pop: the push of I=99 is accepted, `Level` stays 8, `Overflow` stays 0, and 99 emerges last.
- Continuous streaming: push every cycle with `OutReady` randomly toggled at 75% duty, for 1000 samples.
  - Output sequence equals input minus the logged drops.
  - `DropCount` matches the scoreboard.
  - Pointers wrap correctly.
- Async reset asserted mid-cycle with `Level`=5: `OutValid`, `Level`, `Overflow` and `DropCount` go to 0 immediately, without a clock edge. The first push after deassertion appears normally.
